field_extract_mc: RTL and testbench



---
 rtl/field_extract_pkg.sv | 35 +++
 rtl/field_extract_ch.sv | 65 ++++++
 rtl/field_extract_mc.sv | 117 +++++++++++
 tb/tb_field_extract_mc.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/field_extract_pkg.sv
// Shared definitions for the multi-channel header field extractor:
// width codes, parse-action bit layout and the width-code decoder.
package field_extract_pkg;

  // Width codes carried in the action word; 101..111 are invalid.
  localparam logic [2:0] FE_W1 = 3'b000;
  localparam logic [2:0] FE_W2 = 3'b001;
  localparam logic [2:0] FE_W4 = 3'b010;
  localparam logic [2:0] FE_W6 = 3'b011;
  localparam logic [2:0] FE_W8 = 3'b100;

  // Parse-action layout: [0] enable, [3:1] container, [6:4] width, [15:7] offset.
  localparam int unsigned ACT_EN_BIT  = 0;
  localparam int unsigned ACT_IDX_LSB = 1;
  localparam int unsigned ACT_IDX_W   = 3;
  localparam int unsigned ACT_W_LSB   = 4;
  localparam int unsigned ACT_W_W     = 3;
  localparam int unsigned ACT_OFF_LSB = 7;
  localparam int unsigned ACT_OFF_W   = 9;

  // Byte count for a width code; 0 flags an invalid code.
  function automatic logic [3:0] fe_width_bytes(input logic [2:0] code);
    logic [3:0] nb;
    case (code)
      FE_W1:   nb = 4'd1;
      FE_W2:   nb = 4'd2;
      FE_W4:   nb = 4'd4;
      FE_W6:   nb = 4'd6;
      FE_W8:   nb = 4'd8;
      default: nb = 4'd0;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/field_extract_ch.sv
// One extraction channel: decodes a parse action, shifts the header down
// to the requested byte offset and masks the field to its width.
// Optional macro FE_BOUNDS_CHECK_EN flags fields that run past the header end;
// without it, bytes past the end read as zero.
module field_extract_ch
  import field_extract_pkg::*;
#(
  parameter int unsigned HDR_FIELD_LEN = 1024,
  parameter int unsigned ACT_LEN       = 16,
  parameter int unsigned VAL_LEN       = 64
) (
  input  logic [HDR_FIELD_LEN-1:0] hdr,
  input  logic [ACT_LEN-1:0]       action,
  output logic [VAL_LEN-1:0]       value,
  output logic [2:0]               width,
  output logic [2:0]               seq,
  output logic                     valid,
  output logic                     err
);

  logic                 en;
  logic [ACT_OFF_W-1:0] off;
  logic [3:0]           nbytes;
  logic [63:0]          window;
  logic [63:0]          mask;
  logic                 oob;

`ifdef FE_BOUNDS_CHECK_EN
  localparam logic [12:0] HDR_BYTES = 13'(HDR_FIELD_LEN / 8);
  logic [12:0] end_byte;
`endif

  // Decode, shift, mask and classify the channel result.
  always_comb begin
    en     = action[ACT_EN_BIT];
    seq    = action[ACT_IDX_LSB +: ACT_IDX_W];
    width  = action[ACT_W_LSB +: ACT_W_W];
    off    = action[ACT_OFF_LSB +: ACT_OFF_W];
    nbytes = fe_width_bytes(width);
    // Zero padding above the header makes over-the-end bytes read as 0.
    window = 64'({64'b0, hdr} >> {off, 3'b000});
    mask   = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < 32'(nbytes)) mask[8*b +: 8] = 8'hFF;
    end
`ifdef FE_BOUNDS_CHECK_EN
    end_byte = 13'(off) + 13'(nbytes);
    oob      = end_byte > HDR_BYTES;
`else
    oob      = 1'b0;
`endif
    value = '0;
    valid = 1'b0;
    err   = 1'b0;
    if (en) begin
      if (nbytes == 4'd0 || oob) begin
        err = 1'b1;
      end else begin
        valid       = 1'b1;
        value[63:0] = window & mask;
      end
    end
  end

endmodule

// File: rtl/field_extract_mc.sv
// Multi-channel pipelined header field extractor. S1 captures header and
// actions; NUM_CH channel extractors feed the S2 output registers.
// ready/valid on both sides, hdr_cnt counts output handshakes.
// Optional macro FE_BOUNDS_CHECK_EN (see field_extract_ch).
module field_extract_mc
  import field_extract_pkg::*;
#(
  parameter int unsigned HDR_FIELD_LEN = 1024,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned ACT_LEN       = 16,
  parameter int unsigned VAL_LEN       = 64
) (
  input  logic                      axis_clk,
  input  logic                      areset,
  input  logic [HDR_FIELD_LEN-1:0]  pkt_hdr_field,
  input  logic [NUM_CH*ACT_LEN-1:0] parse_actions,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_CH*VAL_LEN-1:0] val_out,
  output logic [NUM_CH*3-1:0]       val_width,
  output logic [NUM_CH*3-1:0]       val_seq,
  output logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               hdr_cnt
);

  logic                      ready_en;
  logic                      s1_valid;
  logic [HDR_FIELD_LEN-1:0]  s1_hdr;
  logic [NUM_CH*ACT_LEN-1:0] s1_act;
  logic                      s2_load;
  logic                      s1_adv;
  logic                      accept;

  logic [VAL_LEN-1:0] ch_value [NUM_CH];
  logic [2:0]         ch_w     [NUM_CH];
  logic [2:0]         ch_s     [NUM_CH];
  logic [NUM_CH-1:0]  ch_v;
  logic [NUM_CH-1:0]  ch_e;

  // Handshake: S2 loads when empty or draining; S1 frees when it advances.
  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_load;
    in_ready = ready_en && (!s1_valid || s1_adv);
    accept   = in_valid && in_ready;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    field_extract_ch #(
      .HDR_FIELD_LEN(HDR_FIELD_LEN),
      .ACT_LEN      (ACT_LEN),
      .VAL_LEN      (VAL_LEN)
    ) u_ch (
      .hdr   (s1_hdr),
      .action(s1_act[c*ACT_LEN +: ACT_LEN]),
      .value (ch_value[c]),
      .width (ch_w[c]),
      .seq   (ch_s[c]),
      .valid (ch_v[c]),
      .err   (ch_e[c])
    );
  end

  // Hold in_ready low through reset and for the release cycle.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // S1: capture header and actions on accept, empty when advanced.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_hdr   <= '0;
      s1_act   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_hdr   <= pkt_hdr_field;
      s1_act   <= parse_actions;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: output registers, frozen while stalled.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      val_out   <= '0;
      val_width <= '0;
      val_seq   <= '0;
      ch_valid  <= '0;
      ch_err    <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          val_out[c*VAL_LEN +: VAL_LEN] <= ch_value[c];
          val_width[c*3 +: 3]           <= ch_w[c];
          val_seq[c*3 +: 3]             <= ch_s[c];
        end
        ch_valid <= ch_v;
        ch_err   <= ch_e;
      end
    end
  end

  // Count completed output handshakes; wraps naturally at 2^32.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset)                      hdr_cnt <= '0;
    else if (out_valid && out_ready) hdr_cnt <= hdr_cnt + 32'd1;
  end

endmodule

// File: tb/tb_field_extract_mc.sv
// Bench for field_extract_mc: byte-level reference model with a scoreboard
// queue checked every output cycle, plus directed literal expectations.
module tb_field_extract_mc;

  localparam int unsigned HDR = 1024;
  localparam int unsigned NCH = 4;
  localparam int unsigned VL  = 64;

  typedef struct packed {
    logic [NCH*VL-1:0] val;
    logic [NCH*3-1:0]  w;
    logic [NCH*3-1:0]  s;
    logic [NCH-1:0]    v;
    logic [NCH-1:0]    e;
  } exp_t;

  logic               clk = 1'b0;
  logic               areset;
  logic [HDR-1:0]     pkt_hdr_field;
  logic [NCH*16-1:0]  parse_actions;
  logic               in_valid;
  logic               in_ready;
  logic [NCH*VL-1:0]  val_out;
  logic [NCH*3-1:0]   val_width;
  logic [NCH*3-1:0]   val_seq;
  logic [NCH-1:0]     ch_valid;
  logic [NCH-1:0]     ch_err;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        hdr_cnt;

  int checks   = 0;
  int failures = 0;

  exp_t        q[$];
  logic [31:0] model_cnt = '0;
  bit          prev_stall = 0;
  logic [NCH*VL+NCH*8+32:0] snap;

  field_extract_mc #(
    .HDR_FIELD_LEN(HDR),
    .NUM_CH       (NCH),
    .ACT_LEN      (16),
    .VAL_LEN      (VL)
  ) dut (
    .axis_clk     (clk),
    .areset       (areset),
    .pkt_hdr_field(pkt_hdr_field),
    .parse_actions(parse_actions),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .val_out      (val_out),
    .val_width    (val_width),
    .val_seq      (val_seq),
    .ch_valid     (ch_valid),
    .ch_err       (ch_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .hdr_cnt      (hdr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HDR-1:0] mk_hdr(input int seed, input int mul);
    logic [HDR-1:0] h;
    for (int i = 0; i < int'(HDR / 8); i++) h[i*8 +: 8] = 8'((i * mul + seed) & 255);
    return h;
  endfunction

  function automatic logic [15:0] mk_act(input bit en, input int idx, input int w, input int off);
    logic [15:0] a;
    a[0]    = en;
    a[3:1]  = 3'(idx);
    a[6:4]  = 3'(w);
    a[15:7] = 9'(off);
    return a;
  endfunction

  // Reference: fetch bytes one at a time from the header.
  function automatic exp_t model(input logic [HDR-1:0] h, input logic [NCH*16-1:0] a);
    exp_t r;
    r = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      logic [15:0] act;
      int nb, off, pos;
      logic [63:0] v;
      bit bad;
      act = a[c*16 +: 16];
      off = int'(act[15:7]);
      r.w[c*3 +: 3] = act[6:4];
      r.s[c*3 +: 3] = act[3:1];
      case (int'(act[6:4]))
        0: nb = 1;
        1: nb = 2;
        2: nb = 4;
        3: nb = 6;
        4: nb = 8;
        default: nb = 0;
      endcase
      if (act[0]) begin
        bad = (nb == 0);
`ifdef FE_BOUNDS_CHECK_EN
        if (off + nb > int'(HDR / 8)) bad = 1;
`endif
        if (bad) begin
          r.e[c] = 1'b1;
        end else begin
          r.v[c] = 1'b1;
          v = '0;
          for (int b = 0; b < nb; b++) begin
            pos = off + b;
            if (pos < int'(HDR / 8)) v[b*8 +: 8] = h[pos*8 +: 8];
          end
          r.val[c*VL +: VL] = v;
        end
      end
    end
    return r;
  endfunction

  // Scoreboard and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (areset) begin
      q.delete();
      model_cnt  = '0;
      prev_stall = 0;
    end else begin
      chk("hdr_cnt", 512'(hdr_cnt), 512'(model_cnt));
      if (prev_stall)
        chk("stable", 512'({out_valid, val_out, val_width, val_seq, ch_valid, ch_err, hdr_cnt}), 512'(snap));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 512'(out_valid), 512'(0));
        end else begin
          chk("val_out",   512'(val_out),   512'(q[0].val));
          chk("val_width", 512'(val_width), 512'(q[0].w));
          chk("val_seq",   512'(val_seq),   512'(q[0].s));
          chk("ch_valid",  512'(ch_valid),  512'(q[0].v));
          chk("ch_err",    512'(ch_err),    512'(q[0].e));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(pkt_hdr_field, parse_actions));
      if (out_valid && out_ready) model_cnt = model_cnt + 32'd1;
      prev_stall = out_valid && !out_ready;
      snap = {out_valid, val_out, val_width, val_seq, ch_valid, ch_err, hdr_cnt};
    end
  end

  task automatic send_one(input logic [HDR-1:0] h, input logic [NCH*16-1:0] a, output int lat);
    int n;
    pkt_hdr_field = h;
    parse_actions = a;
    in_valid      = 1'b1;
    out_ready     = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [HDR-1:0]    h0;
    logic [NCH*16-1:0] acts;
    exp_t              m;
    int                lat, sent, cyc, n;
    bit                acc;
    logic [3:0]        pat;

    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HDR-1:0]    h0;
    logic [NCH*16-1:0] acts;
    exp_t              m;
    int                lat, sent, cyc, n;
    bit                acc;
    logic [3:0]        pat;

    areset        = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    pkt_hdr_field = '0;
    parse_actions = '0;
    h0            = mk_hdr(0, 1);

    // Reset state.
    idle(2);
    chk("rst_in_ready",  512'(in_ready),  512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_hdr_cnt",   512'(hdr_cnt),   512'(0));
    chk("rst_val_out",   512'(val_out),   512'(0));
    areset = 1'b0;
    #1;
    chk("release_in_ready_low", 512'(in_ready), 512'(0));
    @(posedge clk); #1;
    chk("release_in_ready_high", 512'(in_ready), 512'(1));

    // Single 2-byte field at offset 12.
    acts = '0;
    acts[15:0] = mk_act(1, 0, 1, 12);
    m = model(h0, acts);
    chk("model_pin_0d0c", 512'(m.val[63:0]), 512'(64'h0D0C));
    send_one(h0, acts, lat);
    chk("latency", 512'(lat), 512'(2));
    chk("t1_val", 512'(val_out[63:0]), 512'(64'h0D0C));
    chk("t1_chv", 512'(ch_valid), 512'(4'b0001));
    idle(2);

    // Four widths in one beat.
    acts = {mk_act(1, 3, 4, 34), mk_act(1, 2, 3, 26), mk_act(1, 1, 2, 14), mk_act(1, 0, 0, 0)};
    send_one(h0, acts, lat);
    chk("t2_ch0", 512'(val_out[0*VL +: 64]), 512'(64'h00));
    chk("t2_ch1", 512'(val_out[1*VL +: 64]), 512'(64'h11100F0E));
    chk("t2_ch2", 512'(val_out[2*VL +: 64]), 512'(64'h1F1E1D1C1B1A));
    chk("t2_ch3", 512'(val_out[3*VL +: 64]), 512'(64'h2928272625242322));
    chk("t2_chv", 512'(ch_valid), 512'(4'b1111));
    chk("t2_seq", 512'(val_seq), 512'(12'b011_010_001_000));
    idle(2);

    // Invalid width on ch1 only.
    acts = {mk_act(1, 3, 4, 34), mk_act(1, 2, 3, 26), mk_act(1, 1, 6, 14), mk_act(1, 0, 0, 0)};
    send_one(h0, acts, lat);
    chk("t3_err",   512'(ch_err),   512'(4'b0010));
    chk("t3_chv",   512'(ch_valid), 512'(4'b1101));
    chk("t3_ch1",   512'(val_out[1*VL +: 64]), 512'(0));
    chk("t3_ch3",   512'(val_out[3*VL +: 64]), 512'(64'h2928272625242322));
    chk("t3_width", 512'(val_width[5:3]), 512'(3'b110));
    idle(2);

    // Field crossing the header end.
    acts = '0;
    acts[15:0] = mk_act(1, 0, 2, 126);
    send_one(h0, acts, lat);
`ifdef FE_BOUNDS_CHECK_EN
    chk("t4_err", 512'(ch_err[0]), 512'(1));
    chk("t4_val", 512'(val_out[63:0]), 512'(0));
`else
    chk("t4_err", 512'(ch_err[0]), 512'(0));
    chk("t4_chv", 512'(ch_valid[0]), 512'(1));
    chk("t4_val", 512'(val_out[63:0]), 512'(64'h00007F7E));
`endif
    idle(2);
    chk("cnt_after_singles", 512'(hdr_cnt), 512'(4));

    // Stream 8 headers with out_ready pattern 1,0,0,1.
    pat  = 4'b1001;
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 200) begin
      out_ready     = pat[cyc % 4];
      in_valid      = 1'b1;
      pkt_hdr_field = mk_hdr(sent * 13, 7);
      for (int c = 0; c < int'(NCH); c++)
        parse_actions[c*16 +: 16] = mk_act((sent + c) % 5 != 4, c + sent, (sent + c) % 6, sent * 5 + c * 9);
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 512'(sent), 512'(8));
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("stream_drained", 512'(q.size()), 512'(0));
    idle(1);
    chk("stream_hdr_cnt", 512'(hdr_cnt), 512'(12));

    // Reset with two beats in flight.
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    pkt_hdr_field = mk_hdr(5, 3);
    parse_actions = {4{mk_act(1, 1, 1, 3)}};
    @(posedge clk); #1;
    pkt_hdr_field = mk_hdr(9, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", 512'(out_valid), 512'(1));
    areset = 1'b1;
    #1;
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_hdr_cnt",   512'(hdr_cnt),   512'(0));
    chk("midrst_in_ready",  512'(in_ready),  512'(0));
    @(posedge clk); #1;
    areset    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", 512'(out_valid), 512'(0));
    acts = '0;
    acts[15:0] = mk_act(1, 0, 1, 12);
    send_one(h0, acts, lat);
    chk("postrst_latency", 512'(lat), 512'(2));
    chk("postrst_val", 512'(val_out[63:0]), 512'(64'h0D0C));
    idle(2);
    chk("postrst_cnt", 512'(hdr_cnt), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
